// File: rtl/i2c_pkg.sv
// Definitions shared by the I2C master and slave: FSM state encoding,
// open-drain SDA levels and the bit-counter width.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ACK_ADDR = 3'd2,
      ST_RX       = 3'd3,
      ST_ACK_RX   = 3'd4,
      ST_TX       = 3'd5,
      ST_ACK_TX   = 3'd6
   } i2c_state_t;

   localparam logic SDA_RELEASE = 1'b1;
   localparam logic SDA_DRIVE   = 1'b0;
   localparam int   BIT_CNT_W   = 3;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer followed by a registered edge detector for one
// asynchronous bus line. level/rise/fall are aligned, 3 clk after the pin.
module i2c_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync_p0;
   logic sync_p1;

   // Synchronize, then register level and edges together (idle bus is high)
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         level   <= 1'b1;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
         level   <= sync_p1;
         rise    <= sync_p1 & ~level;
         fall    <= ~sync_p1 & level;
      end
   end

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a single 7-bit address. Oversamples SCL/SDA, decodes
// START/STOP, ACKs its address, receives write bytes and serves read bytes.
// Optional: define I2C_SLAVE_GENERAL_CALL_EN to also accept address 8'h00 (write).
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h52
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       sda_in,
   output logic       sda_out,
   input  logic [7:0] data_in,
   output logic       tx_load,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       busy,
   output logic [2:0] state
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_c, stop_c;

   i2c_state_t           state_q, state_n;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_n;
   logic [7:0]           sh_q, sh_n;
   logic [7:0]           dout_q, dout_n;
   logic [7:0]           byte_c;
   logic                 rw_q, rw_n;
   logic                 sda_q, sda_n;
   logic                 busy_q, busy_n;
   logic                 rxv_q, rxv_n;
   logic                 txl_c;

   i2c_sync_edge u_scl (.clk(clk), .rst(rst), .din(sclk),
                        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
   i2c_sync_edge u_sda (.clk(clk), .rst(rst), .din(sda_in),
                        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

   assign start_c = sda_fall & scl_lvl;
   assign stop_c  = sda_rise & scl_lvl;

   function automatic logic addr_match(input logic [7:0] b);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      addr_match = (b[7:1] == SLAVE_ADDR) || (b == 8'h00);
`else
      addr_match = (b[7:1] == SLAVE_ADDR);
`endif
   endfunction

   // Next-state and output decode; STOP, then START, override any bit action
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      sh_n    = sh_q;
      rw_n    = rw_q;
      sda_n   = sda_q;
      busy_n  = busy_q;
      dout_n  = dout_q;
      rxv_n   = 1'b0;
      txl_c   = 1'b0;
      byte_c  = {sh_q[6:0], sda_lvl};
      if (stop_c) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         busy_n  = 1'b0;
         sda_n   = SDA_RELEASE;
      end else if (start_c) begin
         state_n = ST_ADDR;
         cnt_n   = '0;
         busy_n  = 1'b0;
         sda_n   = SDA_RELEASE;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_ADDR: if (scl_rise) begin
               sh_n  = byte_c;
               cnt_n = cnt_q + 1'b1;
               if (cnt_q == 3'd7) begin
                  if (addr_match(byte_c)) begin
                     state_n = ST_ACK_ADDR;
                     busy_n  = 1'b1;
                     rw_n    = byte_c[0];
                  end else begin
                     state_n = ST_IDLE;
                  end
               end
            end
            // cnt_q==0: first fall starts the ACK, cnt_q==1: second fall ends it
            ST_ACK_ADDR, ST_ACK_RX: if (scl_fall) begin
               if (cnt_q == '0) begin
                  sda_n = SDA_DRIVE;
                  cnt_n = 1'b1;
               end else begin
                  cnt_n = '0;
                  if (state_q == ST_ACK_ADDR && rw_q) begin
                     state_n = ST_TX;
                     txl_c   = 1'b1;
                     sh_n    = data_in;
                     sda_n   = data_in[7];
                  end else begin
                     state_n = ST_RX;
                     sda_n   = SDA_RELEASE;
                  end
               end
            end
            ST_RX: if (scl_rise) begin
               sh_n  = byte_c;
               cnt_n = cnt_q + 1'b1;
               if (cnt_q == 3'd7) begin
                  dout_n  = byte_c;
                  rxv_n   = 1'b1;
                  state_n = ST_ACK_RX;
               end
            end
            ST_TX: if (scl_fall) begin
               if (cnt_q == 3'd7) begin
                  cnt_n   = '0;
                  sda_n   = SDA_RELEASE;
                  state_n = ST_ACK_TX;
               end else begin
                  cnt_n = cnt_q + 1'b1;
                  sh_n  = {sh_q[6:0], 1'b0};
                  sda_n = sh_q[6];
               end
            end
            ST_ACK_TX: begin
               if (scl_rise) begin
                  if (sda_lvl) state_n = ST_IDLE;
                  else         cnt_n   = 1'b1;
               end else if (scl_fall && cnt_q == 1'b1) begin
                  cnt_n   = '0;
                  state_n = ST_TX;
                  txl_c   = 1'b1;
                  sh_n    = data_in;
                  sda_n   = data_in[7];
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // Control and visible output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         sda_q   <= SDA_RELEASE;
         busy_q  <= 1'b0;
         rxv_q   <= 1'b0;
         dout_q  <= 8'h00;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         rw_q    <= rw_n;
         sda_q   <= sda_n;
         busy_q  <= busy_n;
         rxv_q   <= rxv_n;
         dout_q  <= dout_n;
      end
   end

   // Shift register is pure datapath and needs no reset
   always_ff @(posedge clk) begin
      sh_q <= sh_n;
   end

   assign sda_out  = sda_q;
   assign data_out = dout_q;
   assign rx_valid = rxv_q;
   assign busy     = busy_q;
   assign tx_load  = txl_c & ~rst;
   assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: acts as the bus master and checks the target against
// a transaction-level model of what it must drive and report.
module tb_i2c_slave;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mscl = 1'b1;
   logic       msda = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       sda_out, tx_load, rx_valid, busy;
   logic [7:0] data_out;
   logic [2:0] state;
   wire        sda_bus;

   assign sda_bus = msda & sda_out;

   i2c_slave #(.SLAVE_ADDR(7'h52)) dut (
      .clk(clk), .rst(rst), .sclk(mscl), .sda_in(sda_bus), .sda_out(sda_out),
      .data_in(data_in), .tx_load(tx_load), .data_out(data_out),
      .rx_valid(rx_valid), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   int         vectors = 0;
   int         errors  = 0;
   int         txl_count = 0;
   int         exp_txl = 0;
   logic [7:0] exp_rx[$];
   logic       chk_en = 1'b0;
   logic       exp_drv = 1'b1;
   logic       prev_txl = 1'b0;
   bit         m_w = 1'b0;
   bit         m_r = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit m_match(input logic [7:0] b);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      return (b[7:1] == 7'h52) || (b == 8'h00);
`else
      return (b[7:1] == 7'h52);
`endif
   endfunction

   // Per-cycle comparison of the DUT against the model's expectations
   always @(negedge clk) begin
      if (!rst) begin
         if (chk_en && mscl) check("sda_out", sda_out, exp_drv);
         if (rx_valid) begin
            check("rx_valid expected", exp_rx.size() > 0, 1);
            if (exp_rx.size() > 0) check("data_out", data_out, exp_rx.pop_front());
         end
         if (tx_load) begin
            txl_count++;
            check("tx_load width", prev_txl, 0);
            check("tx_load/rx_valid overlap", rx_valid, 0);
         end
      end
      prev_txl = tx_load;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
      $fatal(1, "watchdog");
   end

   task automatic tk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      if (!mscl) begin
         tk(5); msda = 1'b1; tk(5); mscl = 1'b1; tk(5);
      end
      msda = 1'b0; tk(5); mscl = 1'b0;
      m_w = 1'b0; m_r = 1'b0;
   endtask

   task automatic do_stop();
      tk(5); msda = 1'b0; tk(5); mscl = 1'b1; tk(5); msda = 1'b1; tk(8);
      check("busy after stop", busy, 0);
      check("state after stop", state, 0);
      check("tx_load count", txl_count, exp_txl);
      check("rx bytes outstanding", exp_rx.size(), 0);
      m_w = 1'b0; m_r = 1'b0;
   endtask

   task automatic clk_bit(input logic b, input logic e, output logic smp);
      tk(5); msda = b; tk(5);
      exp_drv = e; chk_en = 1'b1; mscl = 1'b1;
      tk(4); smp = sda_bus; tk(4);
      mscl = 1'b0; chk_en = 1'b0;
   endtask

   task automatic wr_byte(input logic [7:0] b, input bit is_addr, input bit rst_mid,
                          output logic ack);
      logic s;
      logic e_ack;
      bit   hit;
      if (is_addr) begin
         hit = m_match(b);
         m_w = hit && !b[0];
         m_r = hit && b[0];
         e_ack = !hit;
      end else begin
         e_ack = !m_w;
         if (m_w) exp_rx.push_back(b);
      end
      for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b1, s);
      tk(5); msda = 1'b1; tk(5);
      exp_drv = e_ack; chk_en = 1'b1; mscl = 1'b1; tk(3);
      if (rst_mid) begin
         chk_en = 1'b0;
         rst = 1'b1; tk(1); rst = 1'b0;
         check("sda_out after rst", sda_out, 1);
         check("state after rst", state, 0);
         m_w = 1'b0; m_r = 1'b0; e_ack = 1'b1;
      end else begin
         tk(1);
      end
      ack = sda_bus; tk(4);
      mscl = 1'b0; chk_en = 1'b0;
      check("ack", ack, e_ack);
      if (is_addr) begin
         check("busy after address", busy, m_w | m_r);
         if (m_r) exp_txl++;
      end
   endtask

   task automatic rd_byte(input logic [7:0] exp_b, input logic [7:0] nxt, input bit mack,
                          output logic [7:0] got);
      logic s;
      bit   live;
      live = m_r;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, live ? exp_b[i] : 1'b1, s);
         got[i] = s;
      end
      tk(5); msda = ~mack; tk(5);
      exp_drv = 1'b1; chk_en = 1'b1; mscl = 1'b1;
      tk(4); data_in = nxt; tk(4);
      mscl = 1'b0; chk_en = 1'b0;
      if (live && mack) exp_txl++;
      if (!mack) m_r = 1'b0;
   endtask

   initial begin
      logic       ack;
      logic [7:0] g;
      int         txl0;

      // Reset values
      tk(3);
      check("reset sda_out", sda_out, 1);
      check("reset data_out", data_out, 8'h00);
      check("reset rx_valid", rx_valid, 0);
      check("reset tx_load", tx_load, 0);
      check("reset busy", busy, 0);
      check("reset state", state, 0);
      rst = 1'b0;
      tk(5);

      // Write 0x3C to 0x52
      do_start();
      wr_byte(8'hA4, 1, 0, ack); check("write addr ack", ack, 0);
      wr_byte(8'h3C, 0, 0, ack); check("write data ack", ack, 0);
      check("write data_out", data_out, 8'h3C);
      check("write busy", busy, 1);
      do_stop();

      // Read two bytes, master ACKs then NACKs
      txl0 = txl_count;
      do_start();
      data_in = 8'h81;
      wr_byte(8'hA5, 1, 0, ack); check("read addr ack", ack, 0);
      rd_byte(8'h81, 8'h7E, 1, g); check("read byte0", g, 8'h81);
      rd_byte(8'h7E, 8'h00, 0, g); check("read byte1", g, 8'h7E);
      check("read tx_load pulses", txl_count - txl0, 2);
      do_stop();

      // Address mismatch
      do_start();
      wr_byte(8'hB0, 1, 0, ack); check("mismatch ack", ack, 1);
      check("mismatch busy", busy, 0);
      do_stop();

      // Write then repeated START into a read
      do_start();
      wr_byte(8'hA4, 1, 0, ack);
      wr_byte(8'h11, 0, 0, ack);
      data_in = 8'h5A;
      do_start();
      wr_byte(8'hA5, 1, 0, ack); check("sr read addr ack", ack, 0);
      rd_byte(8'h5A, 8'h00, 0, g); check("sr read byte", g, 8'h5A);
      check("sr data_out kept", data_out, 8'h11);
      do_stop();

      // Reset while the address ACK is driven, then a normal write
      do_start();
      wr_byte(8'hA4, 1, 1, ack); check("ack lost to reset", ack, 1);
      do_start();
      wr_byte(8'hA4, 1, 0, ack); check("post-reset ack", ack, 0);
      wr_byte(8'hC3, 0, 0, ack);
      check("post-reset data_out", data_out, 8'hC3);
      do_stop();

      // General call write and the never-valid general-call read
      do_start();
      wr_byte(8'h00, 1, 0, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      check("gc ack", ack, 0);
      wr_byte(8'h77, 0, 0, ack);
      check("gc data_out", data_out, 8'h77);
`else
      check("gc ack", ack, 1);
`endif
      do_stop();
      do_start();
      wr_byte(8'h01, 1, 0, ack); check("gc read ack", ack, 1);
      do_stop();

      // Randomized transactions, closed by STOP or a repeated START
      for (int t = 0; t < 30; t++) begin
         logic [7:0] a;
         logic [7:0] v[4];
         int         n;
         int         k;
         bit         addressed;
         k = $urandom_range(0, 3);
         case (k)
            0:       a = 8'hA4;
            1:       a = 8'hA5;
            2:       a = 8'($urandom);
            default: a = {7'h00, 1'($urandom)};
         endcase
         n = $urandom_range(1, 3);
         for (int j = 0; j < 4; j++) v[j] = 8'($urandom);
         do_start();
         data_in = v[0];
         wr_byte(a, 1, 0, ack);
         addressed = m_r;
         for (int j = 0; j < n; j++) begin
            if (a[0]) begin
               rd_byte(v[j], v[j+1], j < n - 1, g);
               check("random read byte", g, addressed ? v[j] : 8'hFF);
            end else begin
               wr_byte(v[j], 0, 0, ack);
            end
         end
         if ($urandom_range(0, 1) == 1) do_stop();
      end
      do_stop();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) responding to a single 7-bit address on a bus driven by the team's I2C master. It oversamples `sclk`/`sda_in` on the system clock, detects START/STOP, matches the address, ACKs, and then either receives one or more write bytes or serves read bytes from a parallel port. It sits on the opposite end of the same two-wire interface as the master, with the same open-drain convention: `sda_out = 1` means released.

## Interface
- `SLAVE_ADDR`, default 7'h52: 7-bit bus address matched in the address phase.
- `clk`  in  1: system clock. Must be at least 8x the `sclk` frequency.
- `rst`  in  1: synchronous, active-high reset.
- `sclk`  in  1: serial clock from the master.
- `sda_in`  in  1: serial data as seen on the bus.
- `sda_out`  out  1: serial data drive. 0 pulls low; 1 releases.
- `data_in`  in  8: byte to transmit on a master read. Sampled when `tx_load` is high.
- `tx_load`  out  1: one-cycle pulse when `data_in` is captured.
- `data_out`  out  8: last byte received on a master write.
- `rx_valid`  out  1: one-cycle pulse when `data_out` updates.
- `busy`  out  1: high from address match until STOP or repeated START.
- `state`  out  3: current FSM state, for debug.

## Operation
- **Input sampling:** `sclk` and `sda_in` pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
- **Bus conditions:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state. STOP has priority over any data action in the same cycle.
- **Bit order:** MSB first. Address byte is `{addr[6:0], rw}`, where rw=1 is a read and rw=0 is a write.
- **Bit handling:** Data is sampled on SCL rising edges. `sda_out` changes only on SCL falling edges.
- **FSM states:** IDLE=0, ADDR=1, ACK_ADDR=2, RX=3, ACK_RX=4, TX=5, ACK_TX=6.
  - IDLE → ADDR on START. The bit counter clears.
  - ADDR: shift 8 bits.
    - On the 8th rising edge with a match, → ACK_ADDR and assert `busy`.
    - On a mismatch (without the general-call case), → IDLE. `sda_out` stays released.
  - ACK_ADDR: drive `sda_out=0` from the next falling edge to the following falling edge. At that second falling edge:
    - rw=0 → RX, releasing SDA.
    - rw=1 → TX: pulse `tx_load`, capture `data_in` and drive its MSB.
  - RX: shift 8 bits. On the 8th rising edge, update `data_out` and pulse `rx_valid`, then → ACK_RX.
  - ACK_RX: drive 0 for the 9th clock as in ACK_ADDR, then → RX.
  - TX: after the 8th bit's falling edge, release SDA and → ACK_TX.
  - ACK_TX: sample SDA on the 9th rising edge.
    - Low (ACK): at the next falling edge pulse `tx_load`, capture `data_in` and → TX.
    - High (NACK): → IDLE with SDA released.
- **Repeated START** in any state → ADDR. The counter clears, `busy` drops and SDA is released.
- **STOP** in any state → IDLE, with `busy` low and SDA released.

## Timing
- **Reset values:** `sda_out`=1, `data_out`=8'h00, `rx_valid`=0, `tx_load`=0, `busy`=0, `state`=IDLE.
- **Latency:** bus pin edge to internal edge detect is 3 `clk` cycles (2 synchronizer flops plus 1 edge register). `sda_out` updates 1 cycle after the detected falling edge, i.e. 4 `clk` after the pin edge.
- **Reset mid-transfer:** `sda_out`=1 on the cycle after `rst` is sampled high. The block ignores the bus until the next START.
- **Pulse width:** `rx_valid` and `tx_load` are exactly one `clk` cycle. At most one is high per byte.
- **Host contract:** `data_in` must be stable in the cycle `tx_load` is high. No backpressure exists. Writes are always ACKed.

## Configuration
- `I2C_SLAVE_GENERAL_CALL_EN`
  - Defined: address byte 8'h00 (general call, write) also matches and proceeds exactly as a write. Address 0 with rw=1 is NACKed and → IDLE.
  - Undefined: only `SLAVE_ADDR` matches.

## Structure
- **Package `i2c_pkg`:** FSM state encoding (7 states, 3-bit), `SDA_RELEASE`=1'b1, `SDA_DRIVE`=1'b0, bit-count width.
- **Shared with the master:** the package is used by both master and slave.
- **Sub-module `i2c_sync_edge`:** 2-flop synchronizer plus registered edge detect for one signal. Outputs are `level`, `rise` and `fall`. It is instanced twice, for SCL and SDA. START/STOP decode lives in `i2c_slave`.

## Test plan
- **Write, match:** START, address 0xA4 (7'h52, W), data 0x3C, STOP → ACK after address and data; `rx_valid` pulses once with `data_out`=0x3C; `busy` falls at STOP.
- **Read, 2 bytes:** address 0xA5 (R). `data_in`=0x81, then 0x7E; master ACKs then NACKs → bus carries 10000001, 01111110; `tx_load` pulses twice; SDA released after NACK.
- **Mismatch:** address 0xB0 → no ACK (SDA high on 9th clock), `busy`=0, no pulses; the following STOP leaves IDLE.
- **Repeated START:** write 0xA4 + 0x11, then Sr + 0xA5 read → `data_out`=0x11, then TX starts from ADDR with the counter cleared.
- **Reset mid-ACK:** assert `rst` while driving ACK → `sda_out`=1 next cycle, `state`=IDLE; the next START + 0xA4 is ACKed normally.
- **General call:** address 0x00 write → ACKed only with `I2C_SLAVE_GENERAL_CALL_EN` defined; otherwise NACK.
